// File: rtl/bist_signature_analyzer.sv
// -----------------------------------------------------------------------------
// bist_signature_analyzer
//
// Response-side controller for the scan-chain BIST. It sequences scan_en for
// the pattern generator and the scan chain (shift CHAIN_LEN cycles, capture
// one cycle, repeat NUM_PATTERNS times, then flush the last response). It
// compacts the serial scan_out stream into a single-input signature register
// (SISR), and at the end compares the signature with GOLDEN.
//
// Optional feature macro: BIST_ABORT_EN
//   When defined, this adds the abort input and the aborted output. An abort
//   seen while busy ends the run in DONE with pass=0 and the signature frozen.
//
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   start        in   run request, sampled in IDLE or DONE
//   scan_out     in   serial response from the last flop of the scan chain
//   abort        in   (BIST_ABORT_EN only) abort the current run
//   scan_en      out  1 = chain shifts, 0 = chain captures
//   busy         out  high in SHIFT/CAPTURE/FLUSH
//   done         out  high in DONE
//   pass         out  valid when done: final signature == GOLDEN
//   signature    out  current SISR contents
//   pattern_cnt  out  captures completed this run
//   aborted      out  (BIST_ABORT_EN only) last run ended by abort
// -----------------------------------------------------------------------------
module bist_signature_analyzer #(
    parameter int                   CHAIN_LEN    = 8,
    parameter int                   NUM_PATTERNS = 16,
    parameter int                   SIG_WIDTH    = 8,
    parameter logic [SIG_WIDTH-1:0] TAPS         = 8'b1000_1110,
    parameter logic [SIG_WIDTH-1:0] GOLDEN       = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 scan_out,
`ifdef BIST_ABORT_EN
    input  logic                 abort,
    output logic                 aborted,
`endif
    output logic                 scan_en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [7:0]           pattern_cnt
);

    localparam int             CW         = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CW-1:0]  SHIFT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [7:0]     NP         = 8'(NUM_PATTERNS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t         state;
    logic [CW-1:0]  shift_cnt;
    logic [SIG_WIDTH-1:0] sig_next;
    logic           in_run;

    // SISR step: the tap parity is folded with the incoming bit and shifted
    // in at the LSB.
    assign sig_next = {signature[SIG_WIDTH-2:0], (^(signature & TAPS)) ^ scan_out};

    assign in_run  = (state == SHIFT) || (state == CAPTURE) || (state == FLUSH);
    assign scan_en = (state != CAPTURE);
    assign busy    = in_run;
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_cnt   <= '0;
            signature   <= '0;
            pattern_cnt <= '0;
            pass        <= 1'b0;
`ifdef BIST_ABORT_EN
            aborted     <= 1'b0;
`endif
        end else begin
`ifdef BIST_ABORT_EN
            // Abort wins over normal sequencing. The signature is left
            // untouched on this edge so that it reflects the state at abort.
            if (abort && in_run) begin
                state     <= DONE;
                shift_cnt <= '0;
                pass      <= 1'b0;
                aborted   <= 1'b1;
            end else
`endif
            begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state       <= SHIFT;
                            signature   <= '0;
                            pattern_cnt <= '0;
                            shift_cnt   <= '0;
                            pass        <= 1'b0;
`ifdef BIST_ABORT_EN
                            aborted     <= 1'b0;
`endif
                        end
                    end
                    SHIFT: begin
                        // The first load only flushes out the chain's reset
                        // contents, which carry no response information.
                        if (pattern_cnt != 8'd0)
                            signature <= sig_next;
                        if (shift_cnt == SHIFT_LAST) begin
                            shift_cnt <= '0;
                            state     <= CAPTURE;
                        end else begin
                            shift_cnt <= shift_cnt + CW'(1);
                        end
                    end
                    CAPTURE: begin
                        pattern_cnt <= pattern_cnt + 8'd1;
                        state       <= (pattern_cnt + 8'd1 == NP) ? FLUSH : SHIFT;
                    end
                    FLUSH: begin
                        signature <= sig_next;
                        if (shift_cnt == SHIFT_LAST) begin
                            shift_cnt <= '0;
                            state     <= DONE;
                            // The verdict covers the final compaction on this edge.
                            pass      <= (sig_next == GOLDEN);
                        end else begin
                            shift_cnt <= shift_cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
